seg_time_reader: RTL and testbench



---
 rtl/seg_time_reader.sv | 277 +++++++++++++++++++++++++++
 tb/tb_seg_time_reader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_time_reader.sv
// Seven-segment readback of the six clock digits: skew filter, BCD decode, change classification and tick interval.
// Optional stall detector enabled by defining STALL_DET_EN.
module seg_time_reader #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned STALL_CYCLES  = 50000000
) (
    input  logic             clk,
    input  logic             button_C,
    input  logic [6:0]       seg0,
    input  logic [6:0]       seg1,
    input  logic [6:0]       seg2,
    input  logic [6:0]       seg3,
    input  logic [6:0]       seg4,
    input  logic [6:0]       seg5,
    output logic [7:0]       hh,
    output logic [7:0]       mm,
    output logic [7:0]       ss,
    output logic             time_valid,
    output logic             update,
    output logic [1:0]       evt,
    output logic             err_sticky,
    output logic [CNT_W-1:0] interval,
    output logic             stall
);
    typedef enum logic {EMPTY = 1'b0, TRACK = 1'b1} state_t;

    localparam logic [1:0]       EVT_TICK    = 2'd0;
    localparam logic [1:0]       EVT_MIN_INC = 2'd1;
    localparam logic [1:0]       EVT_CLEAR   = 2'd2;
    localparam logic [1:0]       EVT_ERR     = 2'd3;
    localparam logic [7:0]       STABLE_N    = 8'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(STALL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    // Returns {legal, digit}; anything outside the ten glyphs (blank included) is illegal.
    function automatic logic [4:0] dec7(input logic [6:0] p);
        case (p)
            7'b1000000: dec7 = {1'b1, 4'd0};
            7'b1111001: dec7 = {1'b1, 4'd1};
            7'b0100100: dec7 = {1'b1, 4'd2};
            7'b0110000: dec7 = {1'b1, 4'd3};
            7'b0011001: dec7 = {1'b1, 4'd4};
            7'b0010010: dec7 = {1'b1, 4'd5};
            7'b0000010: dec7 = {1'b1, 4'd6};
            7'b1111000: dec7 = {1'b1, 4'd7};
            7'b0000000: dec7 = {1'b1, 4'd8};
            7'b0010000: dec7 = {1'b1, 4'd9};
            default:    dec7 = {1'b0, 4'd0};
        endcase
    endfunction

    function automatic logic [23:0] tick_bcd(input logic [23:0] t);
        logic [23:0] r;
        r = t;
        if (t == 24'h235959) begin
            r = 24'h000000;
        end else if (t[3:0] != 4'd9) begin
            r[3:0] = t[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (t[7:4] != 4'd5) begin
                r[7:4] = t[7:4] + 4'd1;
            end else begin
                r[7:4] = 4'd0;
                if (t[11:8] != 4'd9) begin
                    r[11:8] = t[11:8] + 4'd1;
                end else begin
                    r[11:8] = 4'd0;
                    if (t[15:12] != 4'd5) begin
                        r[15:12] = t[15:12] + 4'd1;
                    end else begin
                        r[15:12] = 4'd0;
                        if (t[19:16] != 4'd9) begin
                            r[19:16] = t[19:16] + 4'd1;
                        end else begin
                            r[19:16] = 4'd0;
                            r[23:20] = t[23:20] + 4'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] min_inc(input logic [7:0] m);
        if (m == 8'h59) begin
            min_inc = 8'h00;
        end else if (m[3:0] == 4'd9) begin
            min_inc = {m[7:4] + 4'd1, 4'd0};
        end else begin
            min_inc = {m[7:4], m[3:0] + 4'd1};
        end
    endfunction

    logic [41:0]      word_q, prev_q;
    logic [7:0]       stab_q, stab_d;
    logic             diff_s, accept_s;
    logic [4:0]       dd_s;
    logic             all_ok_s, legal_s;
    logic [23:0]      cand_s;
    state_t           state_q, state_d;
    logic [23:0]      time_q, time_d;
    logic             tv_q, tv_d, upd_q, upd_d, err_q, err_d, tick_s;
    logic [1:0]       evt_q, evt_d;
    logic             run_q, run_d;
    logic [CNT_W-1:0] icnt_q, icnt_d, ivl_q, ivl_d;

    // Stability counter: reload on any change, saturate once the pattern has settled.
    always_comb begin
        diff_s = (word_q != prev_q);
        if (diff_s) begin
            stab_d = 8'd1;
        end else if (stab_q < STABLE_N) begin
            stab_d = stab_q + 8'd1;
        end else begin
            stab_d = stab_q;
        end
        accept_s = (stab_d == STABLE_N) && (diff_s || (stab_q != STABLE_N));
    end

    // Decode all six digits of the sampled word and apply the range rules.
    always_comb begin
        dd_s     = 5'd0;
        all_ok_s = 1'b1;
        cand_s   = 24'd0;
        for (int k = 0; k < 6; k++) begin
            dd_s              = dec7(word_q[7*k +: 7]);
            all_ok_s          = all_ok_s & dd_s[4];
            cand_s[4*k +: 4]  = dd_s[3:0];
        end
        legal_s = all_ok_s && (cand_s[7:4] <= 4'd5) && (cand_s[15:12] <= 4'd5) &&
                  ((cand_s[23:20] < 4'd2) || ((cand_s[23:20] == 4'd2) && (cand_s[19:16] <= 4'd3)));
    end

    // Acceptance FSM: load, classify and flag each accepted candidate.
    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        tv_d    = tv_q;
        upd_d   = 1'b0;
        evt_d   = evt_q;
        err_d   = err_q;
        tick_s  = 1'b0;
        if (accept_s) begin
            if (!legal_s) begin
                upd_d = 1'b1;
                evt_d = EVT_ERR;
                err_d = 1'b1;
            end else begin
                case (state_q)
                    EMPTY: begin
                        time_d  = cand_s;
                        tv_d    = 1'b1;
                        upd_d   = 1'b1;
                        evt_d   = (cand_s == 24'h000000) ? EVT_CLEAR : EVT_ERR;
                        state_d = TRACK;
                    end
                    TRACK: begin
                        if (cand_s != time_q) begin
                            time_d = cand_s;
                            upd_d  = 1'b1;
                            if ((cand_s == 24'h000000) && (time_q != 24'h235959)) begin
                                evt_d = EVT_CLEAR;
                            end else if (cand_s == tick_bcd(time_q)) begin
                                evt_d  = EVT_TICK;
                                tick_s = 1'b1;
                            end else if ((cand_s[23:16] == time_q[23:16]) && (cand_s[7:0] == time_q[7:0]) &&
                                         (cand_s[15:8] == min_inc(time_q[15:8]))) begin
                                evt_d = EVT_MIN_INC;
                            end else begin
                                evt_d = EVT_ERR;
                                err_d = 1'b1;
                            end
                        end else begin
                            upd_d = 1'b0;
                        end
                    end
                    default: state_d = EMPTY;
                endcase
            end
        end else begin
            upd_d = 1'b0;
        end
    end

    // Tick interval: the counter only starts running after the first TICK.
    always_comb begin
        ivl_d = ivl_q;
        run_d = run_q;
        if (tick_s) begin
            ivl_d  = run_q ? ((icnt_q == CNT_MAX) ? CNT_MAX : icnt_q + CNT_ONE) : ivl_q;
            icnt_d = {CNT_W{1'b0}};
            run_d  = 1'b1;
        end else if (run_q && (icnt_q != CNT_MAX)) begin
            icnt_d = icnt_q + CNT_ONE;
        end else begin
            icnt_d = icnt_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge button_C) begin
        if (button_C) begin
            word_q  <= 42'd0;
            prev_q  <= 42'd0;
            stab_q  <= 8'd0;
            state_q <= EMPTY;
            time_q  <= 24'd0;
            tv_q    <= 1'b0;
            upd_q   <= 1'b0;
            evt_q   <= 2'd0;
            err_q   <= 1'b0;
            run_q   <= 1'b0;
            icnt_q  <= {CNT_W{1'b0}};
            ivl_q   <= {CNT_W{1'b0}};
        end else begin
            word_q  <= {seg5, seg4, seg3, seg2, seg1, seg0};
            prev_q  <= word_q;
            stab_q  <= stab_d;
            state_q <= state_d;
            time_q  <= time_d;
            tv_q    <= tv_d;
            upd_q   <= upd_d;
            evt_q   <= evt_d;
            err_q   <= err_d;
            run_q   <= run_d;
            icnt_q  <= icnt_d;
            ivl_q   <= ivl_d;
        end
    end

`ifdef STALL_DET_EN
    logic [CNT_W-1:0] scnt_q, scnt_d;
    logic             stall_q, stall_d;

    // Stall counter runs while tracking and restarts on every update.
    always_comb begin
        if (upd_d) begin
            scnt_d = {CNT_W{1'b0}};
        end else if ((state_q == TRACK) && (scnt_q < STALL_LIMIT)) begin
            scnt_d = scnt_q + CNT_ONE;
        end else begin
            scnt_d = scnt_q;
        end
        stall_d = !upd_d && (state_q == TRACK) && (scnt_d >= STALL_LIMIT);
    end

    // Stall registers.
    always_ff @(posedge clk or posedge button_C) begin
        if (button_C) begin
            scnt_q  <= {CNT_W{1'b0}};
            stall_q <= 1'b0;
        end else begin
            scnt_q  <= scnt_d;
            stall_q <= stall_d;
        end
    end

    assign stall = stall_q;
`else
    logic [CNT_W-1:0] unused_stall_limit_s;
    assign unused_stall_limit_s = STALL_LIMIT;
    assign stall = 1'b0;
`endif

    assign hh         = time_q[23:16];
    assign mm         = time_q[15:8];
    assign ss         = time_q[7:0];
    assign time_valid = tv_q;
    assign update     = upd_q;
    assign evt        = evt_q;
    assign err_sticky = err_q;
    assign interval   = ivl_q;
endmodule

// File: tb/tb_seg_time_reader.sv
// Bench for seg_time_reader: directed vector table, hand-written corner sequences and a
// randomized run checked against a seconds-of-day reference model.
module tb_seg_time_reader;
    localparam int STABLE = 4;
    localparam int CW     = 32;

    logic          clk = 1'b0;
    logic          button_C;
    logic [6:0]    seg0, seg1, seg2, seg3, seg4, seg5;
    logic [7:0]    hh, mm, ss;
    logic          time_valid, update, err_sticky, stall;
    logic [1:0]    evt;
    logic [CW-1:0] interval;

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seg_time_reader #(.STABLE_CYCLES(STABLE), .CNT_W(CW), .STALL_CYCLES(50)) dut (
        .clk(clk), .button_C(button_C),
        .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4), .seg5(seg5),
        .hh(hh), .mm(mm), .ss(ss), .time_valid(time_valid), .update(update), .evt(evt),
        .err_sticky(err_sticky), .interval(interval), .stall(stall)
    );

    typedef struct {
        int         h, m, s, gap;
        logic [1:0] evt;
        logic       err;
        int         ivl;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: enc = 7'b1000000;  1: enc = 7'b1111001;  2: enc = 7'b0100100;
            3: enc = 7'b0110000;  4: enc = 7'b0011001;  5: enc = 7'b0010010;
            6: enc = 7'b0000010;  7: enc = 7'b1111000;  8: enc = 7'b0000000;
            9: enc = 7'b0010000;  default: enc = 7'b1111111;
        endcase
    endfunction

    function automatic logic [7:0] bcd(input int v);
        logic [3:0] t, o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    task automatic drive_digits(input int d5, input int d4, input int d3, input int d2, input int d1, input int d0);
        {seg5, seg4, seg3, seg2, seg1, seg0} = {enc(d5), enc(d4), enc(d3), enc(d2), enc(d1), enc(d0)};
    endtask

    task automatic drive_time(input int h, input int m, input int s);
        drive_digits(h / 10, h % 10, m / 10, m % 10, s / 10, s % 10);
    endtask

    task automatic wait_update(input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (update === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        button_C = 1'b1;
        repeat (2) @(negedge clk);
        button_C = 1'b0;
    endtask

    task automatic check_time(input string name, input int h, input int m, input int s);
        check({name, "_time"}, {40'd0, hh, mm, ss}, {40'd0, bcd(h), bcd(m), bcd(s)});
    endtask

    vec_t tbl[10];
    int   lat, n;
    // reference model state
    int   held, nt, op, kind, pos, oh, om, os, nh, nm, nsec;
    int   d[6];
    bit   have, m_err, m_tv, illegal, exp_upd, is_tick;
    int   m_ivl, last_tick;
    logic [1:0] m_evt;

    initial begin
        button_C = 1'b1;
        {seg5, seg4, seg3, seg2, seg1, seg0} = {42{1'b1}};
        repeat (2) @(negedge clk);
        check("reset_outs", {56'd0, hh, mm, ss, time_valid, update, evt, err_sticky, stall},
              64'd0);
        check("reset_ivl", {32'd0, interval}, 64'd0);

        // all zeros right after reset -> CLEAR
        button_C = 1'b0;
        drive_time(0, 0, 0);
        wait_update(10, lat);
        check("first_lat", 64'(lat), 64'(STABLE + 1));
        check_time("first", 0, 0, 0);
        check("first_evt", {62'd0, evt}, 64'd2);
        check("first_tv", {63'd0, time_valid}, 64'd1);
        check("first_err", {63'd0, err_sticky}, 64'd0);

        // directed table
        tbl[0] = '{23, 59, 58, 100, 2'd3, 1'b0, 0};
        tbl[1] = '{23, 59, 59, 100, 2'd0, 1'b0, 0};
        tbl[2] = '{ 0,  0,  0,  37, 2'd0, 1'b0, 100};
        tbl[3] = '{ 0,  0,  1,  20, 2'd0, 1'b0, 37};
        tbl[4] = '{ 0,  1,  1,  30, 2'd1, 1'b0, 37};
        tbl[5] = '{ 0,  0,  0,  40, 2'd2, 1'b0, 37};
        tbl[6] = '{ 0,  0,  1,  25, 2'd0, 1'b0, 90};
        tbl[7] = '{12, 59, 30,  20, 2'd3, 1'b1, 90};
        tbl[8] = '{12,  0, 30,  20, 2'd1, 1'b1, 90};
        tbl[9] = '{12,  0, 45,  20, 2'd3, 1'b1, 90};
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive_time(tbl[k].h, tbl[k].m, tbl[k].s);
            wait_update(12, lat);
            check($sformatf("v%0d_lat", k), 64'(lat), 64'(STABLE + 1));
            check_time($sformatf("v%0d", k), tbl[k].h, tbl[k].m, tbl[k].s);
            check($sformatf("v%0d_evt", k), {62'd0, evt}, {62'd0, tbl[k].evt});
            check($sformatf("v%0d_err", k), {63'd0, err_sticky}, {63'd0, tbl[k].err});
            check($sformatf("v%0d_ivl", k), {32'd0, interval}, 64'(tbl[k].ivl));
            check($sformatf("v%0d_tv", k), {63'd0, time_valid}, 64'd1);
            @(negedge clk);
            check($sformatf("v%0d_pulse", k), {63'd0, update}, 64'd0);
            repeat (tbl[k].gap - lat - 1) @(negedge clk);
        end

        // glitch rejection, illegal blank digit, reset mid-filter
        do_reset();
        drive_time(12, 34, 56);
        wait_update(12, lat);
        check("g_load_evt", {62'd0, evt}, 64'd3);
        check("g_load_err", {63'd0, err_sticky}, 64'd0);
        repeat (5) @(negedge clk);
        seg2 = enc(7);
        repeat (2) @(negedge clk);
        seg2 = enc(4);
        n = 0;
        repeat (14) begin
            @(negedge clk);
            if (update === 1'b1) n++;
        end
        check("glitch_noupd", 64'(n), 64'd0);
        check_time("glitch", 12, 34, 56);
        seg5 = 7'b1111111;
        wait_update(12, lat);
        check("blank_lat", 64'(lat), 64'(STABLE + 1));
        check("blank_evt", {62'd0, evt}, 64'd3);
        check("blank_err", {63'd0, err_sticky}, 64'd1);
        check_time("blank", 12, 34, 56);
        check("blank_tv", {63'd0, time_valid}, 64'd1);
        repeat (3) @(negedge clk);
        drive_time(1, 1, 1);
        repeat (2) @(negedge clk);
        #2 button_C = 1'b1;
        #1;
        check("midrst_outs", {56'd0, hh, mm, ss, time_valid, update, evt, err_sticky, stall}, 64'd0);
        check("midrst_ivl", {32'd0, interval}, 64'd0);
        @(negedge clk);
        button_C = 1'b0;

        // randomized run against the seconds-of-day model
        do_reset();
        held = 0; have = 0; m_err = 0; m_tv = 0; m_ivl = 0; last_tick = -1; m_evt = 2'd0;
        for (int it = 0; it < 80; it++) begin
            op = $urandom_range(0, 10);
            if (!have && (op == 8)) op = 6;
            illegal = 0;
            case (op)
                0, 1, 2, 3: nt = (held + 1) % 86400;
                4:          nt = (held / 3600) * 3600 + (((held / 60) % 60 + 1) % 60) * 60 + held % 60;
                5:          nt = 0;
                7: begin
                    nt = $urandom_range(0, 86399);
                    illegal = 1;
                end
                8:          nt = held;
                9:          nt = 86398 + $urandom_range(0, 1);
                10:         nt = $urandom_range(0, 23) * 3600 + 59 * 60 + $urandom_range(58, 59);
                default:    nt = $urandom_range(0, 86399);
            endcase
            nh = nt / 3600; nm = (nt / 60) % 60; nsec = nt % 60;
            d[5] = nh / 10; d[4] = nh % 10; d[3] = nm / 10; d[2] = nm % 10; d[1] = nsec / 10; d[0] = nsec % 10;
            if (illegal) begin
                kind = $urandom_range(0, 3);
                pos  = $urandom_range(0, 5);
                case (kind)
                    0: d[pos] = 15;
                    1: begin d[5] = 2; d[4] = $urandom_range(4, 9); end
                    2: d[3] = $urandom_range(6, 9);
                    default: d[1] = $urandom_range(6, 9);
                endcase
            end
            drive_digits(d[5], d[4], d[3], d[2], d[1], d[0]);
            exp_upd = 1; is_tick = 0;
            if (illegal) begin
                m_evt = 2'd3; m_err = 1;
            end else if (!have) begin
                held = nt; have = 1; m_tv = 1;
                m_evt = (nt == 0) ? 2'd2 : 2'd3;
            end else if (nt == held) begin
                exp_upd = 0;
            end else begin
                oh = held / 3600; om = (held / 60) % 60; os = held % 60;
                if ((nt == 0) && (held != 86399)) m_evt = 2'd2;
                else if (nt == (held + 1) % 86400) begin m_evt = 2'd0; is_tick = 1; end
                else if ((nh == oh) && (nsec == os) && (nm == (om + 1) % 60)) m_evt = 2'd1;
                else begin m_evt = 2'd3; m_err = 1; end
                held = nt;
            end
            if (exp_upd) begin
                wait_update(12, lat);
                check($sformatf("r%0d_lat", it), 64'(lat), 64'(STABLE + 1));
                if (is_tick) begin
                    if (last_tick >= 0) m_ivl = int'(cyc) - last_tick;
                    last_tick = int'(cyc);
                end
                check_time($sformatf("r%0d", it), held / 3600, (held / 60) % 60, held % 60);
                check($sformatf("r%0d_evt", it), {62'd0, evt}, {62'd0, m_evt});
                check($sformatf("r%0d_err", it), {63'd0, err_sticky}, {63'd0, m_err});
                check($sformatf("r%0d_tv", it), {63'd0, time_valid}, {63'd0, m_tv});
                check($sformatf("r%0d_ivl", it), {32'd0, interval}, 64'(m_ivl));
            end else begin
                n = 0;
                repeat (12) begin
                    @(negedge clk);
                    if (update === 1'b1) n++;
                end
                check($sformatf("r%0d_noupd", it), 64'(n), 64'd0);
            end
            repeat ($urandom_range(2, 30)) @(negedge clk);
        end

        // stall detector
        do_reset();
        drive_time(1, 2, 3);
        wait_update(12, lat);
        n = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if ((stall === 1'b1) && (n < 0)) n = i;
        end
`ifdef STALL_DET_EN
        check("stall_at", 64'(n), 64'd50);
`else
        check("stall_off", 64'(n), 64'hFFFF_FFFF_FFFF_FFFF);
`endif
        drive_time(1, 2, 4);
        wait_update(12, lat);
        check("stall_clr", {63'd0, stall}, 64'd0);
        check("stall_evt", {62'd0, evt}, 64'd0);
        check("stall_err", {63'd0, err_sticky}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
